// File: rtl/dm_ctrl_pkg.sv
// Shared control encodings for the data-memory controller: DMType codes, FSM states, lane helpers.
// Pure definitions; no timing or flow-control behaviour lives here.
package dm_ctrl_pkg;

    typedef enum logic [2:0] {
        DM_WORD  = 3'b000,
        DM_HALF  = 3'b001,
        DM_HALFU = 3'b010,
        DM_BYTE  = 3'b011,
        DM_BYTEU = 3'b100
    } dm_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dm_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } dm_size_e;

    // Undefined codes fall through to word so they behave as full-width accesses.
    function automatic dm_size_e dm_size(input logic [2:0] t);
        case (t)
            DM_HALF, DM_HALFU: return SZ_HALF;
            DM_BYTE, DM_BYTEU: return SZ_BYTE;
            default:           return SZ_WORD;
        endcase
    endfunction

    function automatic logic dm_is_signed(input logic [2:0] t);
        return (t == DM_HALF) || (t == DM_BYTE);
    endfunction

    function automatic logic [3:0] dm_lane_mask(input logic [2:0] t, input logic [1:0] off);
        case (dm_size(t))
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] off);
        case (dm_size(t))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// MEM-stage to data-memory controller bus: access request in, load result and stall/completion out.
// busy is the stall back to the pipeline, which holds its request fields while busy is high.
interface dm_ctrl_if;
    logic        req;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  DMType;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (output req, mem_w, addr, wdata, DMType, input rdata, busy, done, err);
    modport slave  (input req, mem_w, addr, wdata, DMType, output rdata, busy, done, err);
endinterface

// File: rtl/dm_lane_ext.sv
// Load-path lane select plus sign/zero extension of a 32-bit array word.
// Purely combinational, zero latency, no flow control.
module dm_lane_ext
    import dm_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  dm_type,
    output logic [31:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b   = word[8*off +: 8];
        h   = off[1] ? word[31:16] : word[15:0];
        ext = word;
        case (dm_size(dm_type))
            SZ_BYTE: ext = dm_is_signed(dm_type) ? {{24{b[7]}}, b} : {24'h0, b};
            SZ_HALF: ext = dm_is_signed(dm_type) ? {{16{h[15]}}, h} : {16'h0, h};
            default: ext = word;
        endcase
    end
endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: stores complete in one edge (done next cycle); loads finish READ_LAT+1 cycles after accept.
// busy stalls the pipeline from the load-accept cycle through WAIT; DM_MISALIGN_CHK_EN enables misalignment trapping.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1
)(
    input logic       clk,
    input logic       reset,
    dm_ctrl_if.slave  bus
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    logic [31:0]      mem [DEPTH_WORDS];
    dm_state_e        state;
    logic [1:0]       cnt;
    logic [IDX_W+1:0] ld_addr;
    logic [2:0]       ld_type;
    logic [31:0]      rdata_q;
    logic             done_q;
    logic             err_q;

    logic             store_go;
    logic             load_go;
    logic             st_bad;
    logic             ld_bad;
    logic             wr_en;
    logic [IDX_W-1:0] st_idx;
    logic [3:0]       st_mask;
    logic [31:0]      st_data;
    logic [31:0]      ld_word;
    logic [31:0]      ld_ext;

    assign store_go = (state == ST_IDLE) && bus.req && bus.mem_w;
    assign load_go  = (state == ST_IDLE) && bus.req && !bus.mem_w;
    assign st_idx   = bus.addr[IDX_W+1:2];
    assign st_mask  = dm_lane_mask(bus.DMType, bus.addr[1:0]);

    // Replicate the right-aligned store data so every candidate lane sees it.
    always_comb begin
        st_data = bus.wdata;
        case (dm_size(bus.DMType))
            SZ_BYTE: st_data = {4{bus.wdata[7:0]}};
            SZ_HALF: st_data = {2{bus.wdata[15:0]}};
            default: st_data = bus.wdata;
        endcase
    end

`ifdef DM_MISALIGN_CHK_EN
    assign st_bad = dm_misaligned(bus.DMType, bus.addr[1:0]);
    assign ld_bad = dm_misaligned(ld_type, ld_addr[1:0]);
`else
    assign st_bad = 1'b0;
    assign ld_bad = 1'b0;
`endif

    assign wr_en = store_go && !st_bad && !reset;

    // Array has no reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (st_mask[i]) mem[st_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    assign ld_word = mem[ld_addr[IDX_W+1:2]];

    dm_lane_ext u_lane_ext (
        .word    (ld_word),
        .off     (ld_addr[1:0]),
        .dm_type (ld_type),
        .ext     (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 2'd0;
            ld_addr <= '0;
            ld_type <= 3'd0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (store_go) begin
                        done_q <= 1'b1;
                        err_q  <= st_bad;
                    end else if (load_go) begin
                        ld_addr <= bus.addr[IDX_W+1:0];
                        ld_type <= bus.DMType;
                        cnt     <= CNT_INIT;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        state   <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= ld_bad;
                        rdata_q <= ld_bad ? 32'h0 : ld_ext;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.busy  = !reset && ((state == ST_WAIT) || load_go);
endmodule
